alu_share_arbiter: RTL and testbench
====================================

// Module: alu_share_arbiter
// PURPOSE
//  Shares the single 32-bit ALU between NUM_REQ requesters, e.g. port 0 = execute stage, port 1 = address-gen/debug.
//  Each requester has a valid/ready request channel and a valid/ready response channel.
//  A round-robin grant picks one request per cycle and drives the shared ALU combinationally.
//  The ALU result and flags are captured into that port's one-entry response buffer.
// PARAMETERS
//  NUM_REQ   2   number of requesters, legal range 2..4
//  WIDTH     32  operand/result width; must match the ALU
// PORTS
//  clk            in   1                  clock, rising edge
//  rst_n          in   1                  asynchronous, active-low reset
//  req_valid      in   NUM_REQ            per-port request valid
//  req_ready      out  NUM_REQ            per-port request accepted this cycle
//  req_srca       in   NUM_REQ x WIDTH    operand A
//  req_srcb       in   NUM_REQ x WIDTH    operand B
//  req_ctrl       in   NUM_REQ x 4        ALU operation code (alu_op_e)
//  resp_valid     out  NUM_REQ            response buffer full
//  resp_ready     in   NUM_REQ            requester consumes response
//  resp_result    out  NUM_REQ x WIDTH    captured SUM
//  resp_zero      out  NUM_REQ            captured Zero (meaningful for SUB only)
//  resp_slt       out  NUM_REQ            captured signed-less flag
//  resp_sltu      out  NUM_REQ            captured unsigned-less flag
//  alu_srca       out  WIDTH              to ALU SrcA
//  alu_srcb       out  WIDTH              to ALU SrcB
//  alu_ctrl       out  4                  to ALU ALUControl
//  alu_sum        in   WIDTH              from ALU SUM
//  alu_zero       in   1                  from ALU Zero
//  alu_slt        in   1                  from ALU signedLess
//  alu_sltu       in   1                  from ALU unsignedLess
// BEHAVIOUR
//  Reset values: all resp_valid=0; resp_result/flags=0; rr_ptr=0; req_ready=0 while rst_n=0.
//  Eligibility: port i is eligible when req_valid[i] && (!resp_valid[i] || resp_ready[i]).
//  Grant: at most one grant per cycle. The grant goes to the first eligible port at or after rr_ptr, modulo NUM_REQ.
//  rr_ptr: after a grant to port g, rr_ptr <= (g+1) mod NUM_REQ. rr_ptr is unchanged when there is no grant.
//  req_ready[i] = grant[i]. Grant is combinational from current inputs and state, with no combinational path from req_ready back to req_valid.
//  ALU drive: granted port's srca/srcb/ctrl pass through combinationally. With no grant, alu_srca=0, alu_srcb=0, alu_ctrl=4'b0000.
//  Latency: a request accepted in cycle N gives resp_valid=1 in cycle N+1, holding alu_sum/flags sampled at the end of cycle N.
//  Response: resp_* stays stable while resp_valid && !resp_ready.
//    - Buffer clears on resp_ready unless refilled the same cycle.
//    - Simultaneous drain and refill keeps resp_valid=1 with the new data.
//  Requester rules: req_srca/req_srcb/req_ctrl must stay stable while req_valid && !req_ready. A requester may drop req_valid only after acceptance.
//  Starvation bound: with all ports continuously eligible, each is granted at least once every NUM_REQ cycles.
//  A port with a full, undrained buffer is skipped and does not block the others.
//  Undefined ctrl codes (4'b1011..4'b1111) are forwarded unchanged; the ALU returns SUM=0. No error is flagged.
//  Reset mid-operation: buffered, unconsumed responses are discarded. Requesters must re-issue.
//  Widths: no arithmetic here; all data is passed bit-exact. The shift amount is the full SrcB, as the ALU defines it.
// STRUCTURE
//  Package alu_pkg holds:
//    - typedef enum logic [3:0] alu_op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLTU=5, SLT=6, PASSB=7, SLL=8, SRL=9, SRA=10
//    - localparam MAX_REQ=4
//    - typedef struct alu_resp_t {sum, zero, slt, sltu}
//  Sub-module rr_arbiter (NUM_REQ): inputs eligible vector and rr_ptr; outputs one-hot grant and grant index.
//  Top level holds rr_ptr, the per-port response buffers and the operand mux.
// TESTING
//  1. Reset: hold rst_n=0 with req_valid=2'b11. Expect req_ready=0 and resp_valid=0. Release reset: one grant next cycle, to port 0.
//  2. Single op: port0 ADD 5+7 at cycle N. Expect req_ready[0]=1 in cycle N, and resp_valid[0]=1, resp_result=12 in cycle N+1.
//  3. Contention: both ports request continuously with resp_ready=1. Expect alternating grants 0,1,0,1.
//       Port0 SUB 3-3 -> result 0, zero=1. Port1 SLT -1<1 -> result 1.
//  4. Backpressure: port0 resp_ready=0 after its first result.
//       - Port0 gets no further grant; port1 gets every cycle.
//       - resp_result[0] holds its value until resp_ready[0]=1.
//  5. Drain+refill: resp_valid[0]=1 with resp_ready[0]=1 and a new SRA 0x80000000>>>4 in the same cycle.
//       Expect resp_valid[0] to stay 1 with result 0xF8000000.
//  6. Mid-op reset: assert rst_n=0 while both buffers are full. Expect resp_valid=0 asynchronously and rr_ptr=0 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU opcode, sizing and response types
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_AND   = 4'd2,
        ALU_OR    = 4'd3,
        ALU_XOR   = 4'd4,
        ALU_SLTU  = 4'd5,
        ALU_SLT   = 4'd6,
        ALU_PASSB = 4'd7,
        ALU_SLL   = 4'd8,
        ALU_SRL   = 4'd9,
        ALU_SRA   = 4'd10
    } alu_op_e;

    localparam int MAX_REQ   = 4;
    localparam int ALU_WIDTH = 32;

    typedef struct packed {
        logic [ALU_WIDTH-1:0] sum;
        logic                 zero;
        logic                 slt;
        logic                 sltu;
    } alu_resp_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first eligible port at or after rr_ptr
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] eligible,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [PTR_W-1:0]   grant_idx,
    output logic               grant_valid
);

    int idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            // rr_ptr is always below NUM_REQ, so one subtraction wraps the index
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!grant_valid && eligible[idx]) begin
                grant[idx]  = 1'b1;
                grant_idx   = idx[PTR_W-1:0];
                grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - shares one ALU between NUM_REQ requesters with per-port response buffers
module alu_share_arbiter
    import alu_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_srca,
    input  logic [NUM_REQ-1:0][WIDTH-1:0] req_srcb,
    input  logic [NUM_REQ-1:0][3:0]       req_ctrl,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [NUM_REQ-1:0][WIDTH-1:0] resp_result,
    output logic [NUM_REQ-1:0]            resp_zero,
    output logic [NUM_REQ-1:0]            resp_slt,
    output logic [NUM_REQ-1:0]            resp_sltu,
    output logic [WIDTH-1:0]              alu_srca,
    output logic [WIDTH-1:0]              alu_srcb,
    output logic [3:0]                    alu_ctrl,
    input  logic [WIDTH-1:0]              alu_sum,
    input  logic                          alu_zero,
    input  logic                          alu_slt,
    input  logic                          alu_sltu
);

    localparam int PTR_W = $clog2(MAX_REQ);

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   grant_idx;
    logic [NUM_REQ-1:0] eligible;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;

    // A full buffer may still accept if it is being drained this same cycle
    always_comb begin
        eligible = req_valid & (~resp_valid | resp_ready) & {NUM_REQ{rst_n}};
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .eligible    (eligible),
        .rr_ptr      (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign req_ready = grant;

    always_comb begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_ctrl = 4'b0000;
        if (grant_valid) begin
            alu_srca = req_srca[grant_idx];
            alu_srcb = req_srcb[grant_idx];
            alu_ctrl = req_ctrl[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else if (grant_valid) begin
            rr_ptr <= (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid  <= '0;
            resp_result <= '0;
            resp_zero   <= '0;
            resp_slt    <= '0;
            resp_sltu   <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (grant[i]) begin
                    resp_valid[i]  <= 1'b1;
                    resp_result[i] <= alu_sum;
                    resp_zero[i]   <= alu_zero;
                    resp_slt[i]    <= alu_slt;
                    resp_sltu[i]   <= alu_sltu;
                end else if (resp_ready[i]) begin
                    resp_valid[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;
    import alu_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][31:0] req_srca;
    logic [1:0][31:0] req_srcb;
    logic [1:0][3:0]  req_ctrl;
    logic [1:0]       resp_valid;
    logic [1:0]       resp_ready;
    logic [1:0][31:0] resp_result;
    logic [1:0]       resp_zero;
    logic [1:0]       resp_slt;
    logic [1:0]       resp_sltu;
    logic [31:0]      alu_srca;
    logic [31:0]      alu_srcb;
    logic [3:0]       alu_ctrl;
    logic [31:0]      alu_sum;
    logic             alu_zero;
    logic             alu_slt;
    logic             alu_sltu;

    int total;
    int bad;

    alu_share_arbiter #(.NUM_REQ(2), .WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_srca    (req_srca),
        .req_srcb    (req_srcb),
        .req_ctrl    (req_ctrl),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_zero   (resp_zero),
        .resp_slt    (resp_slt),
        .resp_sltu   (resp_sltu),
        .alu_srca    (alu_srca),
        .alu_srcb    (alu_srcb),
        .alu_ctrl    (alu_ctrl),
        .alu_sum     (alu_sum),
        .alu_zero    (alu_zero),
        .alu_slt     (alu_slt),
        .alu_sltu    (alu_sltu)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural shared ALU
    always_comb begin
        case (alu_ctrl)
            4'd0:    alu_sum = alu_srca + alu_srcb;
            4'd1:    alu_sum = alu_srca - alu_srcb;
            4'd2:    alu_sum = alu_srca & alu_srcb;
            4'd3:    alu_sum = alu_srca | alu_srcb;
            4'd4:    alu_sum = alu_srca ^ alu_srcb;
            4'd5:    alu_sum = {31'b0, alu_srca < alu_srcb};
            4'd6:    alu_sum = {31'b0, $signed(alu_srca) < $signed(alu_srcb)};
            4'd7:    alu_sum = alu_srcb;
            4'd8:    alu_sum = alu_srca << alu_srcb;
            4'd9:    alu_sum = alu_srca >> alu_srcb;
            4'd10:   alu_sum = $signed(alu_srca) >>> alu_srcb;
            default: alu_sum = 32'd0;
        endcase
        alu_zero = (alu_sum == 32'd0);
        alu_slt  = $signed(alu_srca) < $signed(alu_srcb);
        alu_sltu = alu_srca < alu_srcb;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        req_srca[0] = 32'd5;  req_srcb[0] = 32'd7; req_ctrl[0] = ALU_ADD;
        req_srca[1] = 32'd1;  req_srcb[1] = 32'd2; req_ctrl[1] = ALU_ADD;

        // reset with both ports requesting
        cyc(); cyc(); cyc();
        #1;
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
        check_eq("rst_alu_srca", alu_srca, 32'd0);
        check_eq("rst_alu_ctrl", 32'(alu_ctrl), 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_grant", 32'(req_ready), 32'b01);
        check_eq("post_rst_alu_srca", alu_srca, 32'd5);
        cyc();
        check_eq("first_resp_valid", 32'(resp_valid), 32'b01);
        check_eq("first_result", resp_result[0], 32'd12);
        check_eq("second_grant", 32'(req_ready), 32'b10);
        cyc();
        req_valid = 2'b00;
        #1;
        check_eq("p1_resp_valid", 32'(resp_valid), 32'b10);
        check_eq("p1_result", resp_result[1], 32'd3);
        check_eq("idle_alu_srcb", alu_srcb, 32'd0);
        cyc();
        check_eq("drained", 32'(resp_valid), 32'b00);

        // single op on port 0 (rr_ptr is 0 here)
        req_valid = 2'b01;
        #1;
        check_eq("single_ready", 32'(req_ready), 32'b01);
        cyc();
        req_valid = 2'b00;
        #1;
        check_eq("single_valid", 32'(resp_valid), 32'b01);
        check_eq("single_result", resp_result[0], 32'd12);
        cyc();

        // contention after a fresh reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req_srca[0] = 32'd3;          req_srcb[0] = 32'd3; req_ctrl[0] = ALU_SUB;
        req_srca[1] = 32'hFFFF_FFFF;  req_srcb[1] = 32'd1; req_ctrl[1] = ALU_SLT;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq($sformatf("contend_grant%0d", i), 32'(req_ready), (i % 2 == 0) ? 32'b01 : 32'b10);
            cyc();
        end
        check_eq("sub_result", resp_result[0], 32'd0);
        check_eq("sub_zero", 32'(resp_zero[0]), 32'd1);
        check_eq("slt_result", resp_result[1], 32'd1);
        check_eq("slt_flag", 32'(resp_slt[1]), 32'd1);
        check_eq("slt_sltu", 32'(resp_sltu[1]), 32'd0);

        // backpressure on port 0 (rr_ptr is 0 here)
        req_srca[0] = 32'd10;      req_srcb[0] = 32'd20;      req_ctrl[0] = ALU_ADD;
        req_srca[1] = 32'h0000_F0F0; req_srcb[1] = 32'h0000_0FF0; req_ctrl[1] = ALU_XOR;
        resp_ready = 2'b10;
        #1;
        check_eq("bp_first_grant", 32'(req_ready), 32'b01);
        cyc();
        req_srca[0] = 32'd100; req_srcb[0] = 32'd1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check_eq($sformatf("bp_grant%0d", i), 32'(req_ready), 32'b10);
            check_eq($sformatf("bp_hold%0d", i), resp_result[0], 32'd30);
            check_eq($sformatf("bp_valid%0d", i), 32'(resp_valid[0]), 32'd1);
            cyc();
        end
        check_eq("xor_result", resp_result[1], 32'h0000_FF00);

        // drain and refill port 0 in the same cycle
        req_srca[0] = 32'h8000_0000; req_srcb[0] = 32'd4; req_ctrl[0] = ALU_SRA;
        req_valid  = 2'b01;
        resp_ready = 2'b11;
        #1;
        check_eq("refill_grant", 32'(req_ready), 32'b01);
        cyc();
        req_valid = 2'b00;
        #1;
        check_eq("refill_valid", 32'(resp_valid[0]), 32'd1);
        check_eq("refill_result", resp_result[0], 32'hF800_0000);

        // undefined opcode is forwarded unchanged
        req_srca[1] = 32'd9; req_srcb[1] = 32'd9; req_ctrl[1] = 4'hC;
        req_valid = 2'b10;
        #1;
        check_eq("undef_grant", 32'(req_ready), 32'b10);
        check_eq("undef_ctrl", 32'(alu_ctrl), 32'hC);
        cyc();
        req_valid = 2'b00;
        #1;
        check_eq("undef_result", resp_result[1], 32'd0);
        cyc();

        // fill port 1 then port 0 so rr_ptr ends at 1, then reset mid-operation
        resp_ready = 2'b00;
        req_ctrl[0] = ALU_PASSB; req_srcb[0] = 32'hAAAA_5555;
        req_ctrl[1] = ALU_OR;    req_srca[1] = 32'h0F00; req_srcb[1] = 32'h00F0;
        req_valid = 2'b10;
        cyc();
        req_valid = 2'b01;
        cyc();
        req_valid = 2'b00;
        #1;
        check_eq("full_both", 32'(resp_valid), 32'b11);
        check_eq("passb_result", resp_result[0], 32'hAAAA_5555);
        check_eq("or_result", resp_result[1], 32'h0000_0FF0);
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(resp_valid), 32'b00);
        check_eq("async_rst_result", resp_result[0], 32'd0);
        cyc();
        rst_n = 1'b1;
        req_valid  = 2'b11;
        resp_ready = 2'b11;
        #1;
        check_eq("rr_ptr_reset_grant", 32'(req_ready), 32'b01);
        cyc();
        req_valid = 2'b00;
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
